write_back_stage: RTL and testbench
===================================

# write_back_stage

Parametrised MIPS write-back stage with an internal MEM/WB pipeline register, a result select, load-data extraction and sign/zero extension, link-register override for jump-and-link, and stall/flush control. It sits between the memory stage and the register file. Each cycle it delivers one register-file write (data, address, enable) and a retired-instruction count for debug.

## Interface
Parameters:
- NB_DATA, 32, data width; must be a multiple of 8 and at least 32
- NB_REG_ADDRESS, 5, register address width
- LINK_REG, 31, destination register forced by jump-and-link
- NB_COUNT, 32, width of the retired-instruction counter

Ports:
- i_clock  in  1  single clock; all state updates on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_stall  in  1  hold the pipeline register
- i_flush  in  1  squash the incoming instruction
- i_valid  in  1  memory stage presents a valid instruction
- i_dato_de_mem  in  NB_DATA  raw word read from data memory
- i_alu_result  in  NB_DATA  ALU result / effective address
- i_pc_link  in  NB_DATA  return address (PC+8) for link instructions
- i_direc_reg  in  NB_REG_ADDRESS  destination register
- i_reg_write  in  1  instruction writes the register file
- i_mem_to_reg  in  1  result comes from memory, not the ALU
- i_j_return_dest  in  1  jump-and-link: destination LINK_REG, data i_pc_link
- i_load_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- i_load_unsigned  in  1  zero-extend, not sign-extend
- i_byte_offset  in  2  low address bits of the load
- o_dato  out  NB_DATA  register-file write data
- o_direccion  out  NB_REG_ADDRESS  register-file write address
- o_reg_write  out  1  register-file write enable
- o_valid  out  1  registered instruction valid
- o_retired_count  out  NB_COUNT  instructions retired since reset

## Operation
- The pipeline register captures all i_* data and control fields.
- Update priority at each rising edge: i_reset, then i_flush, then i_stall, then normal capture.
  - Reset: all register fields cleared, counter cleared.
  - Flush: valid and reg_write cleared, data fields don't-care. Flush wins over a simultaneous stall.
  - Stall: register holds.
  - Capture: valid = i_valid; if i_valid=0, reg_write is captured as 0.
- Data select (combinational from the register):
  - j_return_dest=1 → pc_link
  - else mem_to_reg=1 → extended load data
  - else → alu_result
- Address: j_return_dest=1 → LINK_REG, else direc_reg.
- o_reg_write = valid & reg_write & (o_direccion != 0). Writes to r0 are always suppressed.
- Load extraction uses little-endian lanes; byte k = bits [8k+7:8k] of the low 32 bits.
  - Byte: lane i_byte_offset.
  - Half: lane pair selected by offset[1]; offset[0] is ignored (misaligned loads are not trapped here).
  - Word: offset ignored, full NB_DATA passed through.
  - Byte and half are extended to NB_DATA: zeros if load_unsigned, otherwise the replicated top bit.
- Counter increments by 1 at an edge where valid=1 and i_stall=0 and no reset (the held instruction leaves). It wraps modulo 2^NB_COUNT.
- A flush on the same edge does not block counting the outgoing instruction.

## Timing
- Latency: 1 cycle from input to o_dato/o_direccion/o_reg_write. Outputs are purely combinational from the register; there is no input-to-output combinational path.
- Reset values: o_dato=0, o_direccion=0, o_reg_write=0, o_valid=0, o_retired_count=0.
- During a stall, outputs repeat the same write each cycle. The register file must tolerate idempotent rewrites.
- Reset asserted mid-stall or mid-flush clears everything on that edge. The first capture happens on the edge after reset deasserts.

## Structure
- Shared package (mips_pkg): load-size encodings LS_BYTE/LS_HALF/LS_WORD, default LINK_REG.
- Sub-module load_extender: purely combinational; inputs are data, size, unsigned and offset; output is the extended word.
- The top level holds the pipeline register, result select and counter.

## Test plan
- Reset then idle: all outputs 0. Then capture ALU write: alu=0x12345678, direc=5, reg_write=1, valid=1 → next cycle o_dato=0x12345678, o_direccion=5, o_reg_write=1, count=0; one idle cycle later count=1.
- Loads from mem=0x80FF7F01:
  - byte offset 2, signed → 0xFFFFFFFF
  - byte offset 3, unsigned → 0x00000080
  - half offset 0, signed → 0x00007F01
  - half offset 3, signed → 0xFFFF80FF (bit0 ignored)
  - word → 0x80FF7F01
- Jump-and-link: j_return_dest=1, pc_link=0x00400010, direc=7 → o_direccion=31, o_dato=0x00400010, o_reg_write=1.
- r0 write: direc=0, reg_write=1 → o_reg_write=0. Invalid input with reg_write=1 → o_reg_write=0.
- Stall and flush:
  - Stall held 3 cycles → outputs constant, count frozen.
  - Flush and stall asserted together → o_valid=0 and o_reg_write=0 next cycle.
- Reset mid-stream with count=5 and a valid instruction registered → all outputs 0 next cycle. Counter preset near 2^NB_COUNT−1 wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: load-size encodings, default link register, extension helper.
// No logic of its own; imported by the write-back stage and its load extender.
package mips_pkg;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   localparam int DEFAULT_LINK_REG = 31;

   // Fill bit for widening a narrow load: replicated sign for signed loads, zero otherwise.
   function automatic logic ext_fill(input logic top_bit, input logic is_unsigned);
      return top_bit & ~is_unsigned;
   endfunction

endpackage

// File: rtl/write_back_stage_if.sv
// Memory-stage to write-back bundle: instruction fields and control in, register-file write out.
// The slave side is the write-back stage; the master side is the memory stage / register file.
interface write_back_stage_if #(
   parameter int NB_DATA        = 32,
   parameter int NB_REG_ADDRESS = 5,
   parameter int NB_COUNT       = 32
);

   logic                      i_stall;
   logic                      i_flush;
   logic                      i_valid;
   logic [NB_DATA-1:0]        i_dato_de_mem;
   logic [NB_DATA-1:0]        i_alu_result;
   logic [NB_DATA-1:0]        i_pc_link;
   logic [NB_REG_ADDRESS-1:0] i_direc_reg;
   logic                      i_reg_write;
   logic                      i_mem_to_reg;
   logic                      i_j_return_dest;
   logic [1:0]                i_load_size;
   logic                      i_load_unsigned;
   logic [1:0]                i_byte_offset;

   logic [NB_DATA-1:0]        o_dato;
   logic [NB_REG_ADDRESS-1:0] o_direccion;
   logic                      o_reg_write;
   logic                      o_valid;
   logic [NB_COUNT-1:0]       o_retired_count;

   modport master (
      output i_stall, i_flush, i_valid, i_dato_de_mem, i_alu_result, i_pc_link,
             i_direc_reg, i_reg_write, i_mem_to_reg, i_j_return_dest,
             i_load_size, i_load_unsigned, i_byte_offset,
      input  o_dato, o_direccion, o_reg_write, o_valid, o_retired_count
   );

   modport slave (
      input  i_stall, i_flush, i_valid, i_dato_de_mem, i_alu_result, i_pc_link,
             i_direc_reg, i_reg_write, i_mem_to_reg, i_j_return_dest,
             i_load_size, i_load_unsigned, i_byte_offset,
      output o_dato, o_direccion, o_reg_write, o_valid, o_retired_count
   );

endinterface

// File: rtl/load_extender.sv
// Load-data lane extraction (little-endian) with sign/zero extension to NB_DATA.
// Purely combinational, zero latency, no flow control.
module load_extender
   import mips_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [NB_DATA-1:0] data,
   input  logic [1:0]         size,
   input  logic               is_unsigned,
   input  logic [1:0]         offset,
   output logic [NB_DATA-1:0] ext
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = data[7:0];
      case (offset)
         2'd1:    lane_b = data[15:8];
         2'd2:    lane_b = data[23:16];
         2'd3:    lane_b = data[31:24];
         default: lane_b = data[7:0];
      endcase
   end

   // offset[0] is deliberately ignored: misaligned halfword loads are not trapped here
   assign lane_h = offset[1] ? data[31:16] : data[15:0];

   always_comb begin
      ext = data;
      case (size)
         LS_BYTE: ext = {{(NB_DATA-8){ext_fill(lane_b[7], is_unsigned)}}, lane_b};
         LS_HALF: ext = {{(NB_DATA-16){ext_fill(lane_h[15], is_unsigned)}}, lane_h};
         LS_WORD: ext = data;
         default: ext = data;
      endcase
   end

endmodule

// File: rtl/write_back_stage.sv
// MEM/WB register, result select, link override and retired counter; 1-cycle latency to the register file.
// No backpressure path: i_stall holds the register, i_flush squashes the incoming instruction.
module write_back_stage
   import mips_pkg::*;
#(
   parameter int NB_DATA        = 32,
   parameter int NB_REG_ADDRESS = 5,
   parameter int LINK_REG       = DEFAULT_LINK_REG,
   parameter int NB_COUNT       = 32
) (
   input logic               i_clock,
   input logic               i_reset,
   write_back_stage_if.slave wb
);

   typedef struct packed {
      logic                      valid;
      logic                      reg_write;
      logic                      mem_to_reg;
      logic                      j_return_dest;
      logic [1:0]                load_size;
      logic                      load_unsigned;
      logic [1:0]                byte_offset;
      logic [NB_REG_ADDRESS-1:0] direc_reg;
      logic [NB_DATA-1:0]        dato_de_mem;
      logic [NB_DATA-1:0]        alu_result;
      logic [NB_DATA-1:0]        pc_link;
   } mem_wb_t;

   mem_wb_t                   wb_d;
   mem_wb_t                   wb_q;
   logic [NB_COUNT-1:0]       retired_q;
   logic [NB_DATA-1:0]        load_ext;
   logic [NB_DATA-1:0]        dato;
   logic [NB_REG_ADDRESS-1:0] direccion;

   always_comb begin
      wb_d               = '0;
      wb_d.valid         = wb.i_valid;
      wb_d.reg_write     = wb.i_valid & wb.i_reg_write;
      wb_d.mem_to_reg    = wb.i_mem_to_reg;
      wb_d.j_return_dest = wb.i_j_return_dest;
      wb_d.load_size     = wb.i_load_size;
      wb_d.load_unsigned = wb.i_load_unsigned;
      wb_d.byte_offset   = wb.i_byte_offset;
      wb_d.direc_reg     = wb.i_direc_reg;
      wb_d.dato_de_mem   = wb.i_dato_de_mem;
      wb_d.alu_result    = wb.i_alu_result;
      wb_d.pc_link       = wb.i_pc_link;
   end

   // The outgoing instruction is counted even when a flush squashes the incoming one.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wb_q      <= '0;
         retired_q <= '0;
      end else begin
         if (wb_q.valid && !wb.i_stall) begin
            retired_q <= retired_q + NB_COUNT'(1);
         end
         if (wb.i_flush) begin
            wb_q.valid     <= 1'b0;
            wb_q.reg_write <= 1'b0;
         end else if (!wb.i_stall) begin
            wb_q <= wb_d;
         end
      end
   end

   load_extender #(
      .NB_DATA (NB_DATA)
   ) u_load_extender (
      .data        (wb_q.dato_de_mem),
      .size        (wb_q.load_size),
      .is_unsigned (wb_q.load_unsigned),
      .offset      (wb_q.byte_offset),
      .ext         (load_ext)
   );

   always_comb begin
      dato      = wb_q.alu_result;
      direccion = wb_q.direc_reg;
      if (wb_q.j_return_dest) begin
         dato      = wb_q.pc_link;
         direccion = NB_REG_ADDRESS'(LINK_REG);
      end else if (wb_q.mem_to_reg) begin
         dato = load_ext;
      end
   end

   assign wb.o_dato          = dato;
   assign wb.o_direccion     = direccion;
   assign wb.o_reg_write     = wb_q.valid & wb_q.reg_write & (|direccion);
   assign wb.o_valid         = wb_q.valid;
   assign wb.o_retired_count = retired_q;

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed vector table, hand sequences, random vs. model.
module tb_write_back_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   write_back_stage_if #(.NB_DATA(32), .NB_REG_ADDRESS(5), .NB_COUNT(32)) wb ();
   write_back_stage_if #(.NB_DATA(32), .NB_REG_ADDRESS(5), .NB_COUNT(4))  wb4 ();

   write_back_stage #(.NB_DATA(32), .NB_REG_ADDRESS(5), .LINK_REG(31), .NB_COUNT(32)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .wb      (wb)
   );

   // Narrow-counter copy driven identically, used to observe counter wrap.
   write_back_stage #(.NB_DATA(32), .NB_REG_ADDRESS(5), .LINK_REG(31), .NB_COUNT(4)) dut4 (
      .i_clock (clk),
      .i_reset (rst),
      .wb      (wb4)
   );

   assign wb4.i_stall         = wb.i_stall;
   assign wb4.i_flush         = wb.i_flush;
   assign wb4.i_valid         = wb.i_valid;
   assign wb4.i_dato_de_mem   = wb.i_dato_de_mem;
   assign wb4.i_alu_result    = wb.i_alu_result;
   assign wb4.i_pc_link       = wb.i_pc_link;
   assign wb4.i_direc_reg     = wb.i_direc_reg;
   assign wb4.i_reg_write     = wb.i_reg_write;
   assign wb4.i_mem_to_reg    = wb.i_mem_to_reg;
   assign wb4.i_j_return_dest = wb.i_j_return_dest;
   assign wb4.i_load_size     = wb.i_load_size;
   assign wb4.i_load_unsigned = wb.i_load_unsigned;
   assign wb4.i_byte_offset   = wb.i_byte_offset;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic [31:0] mem, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [4:0] dir, input logic rw, input logic m2r, input logic jal,
                         input logic [1:0] size, input logic uns, input logic [1:0] off,
                         input logic v);
      wb.i_dato_de_mem   = mem;
      wb.i_alu_result    = alu;
      wb.i_pc_link       = pc;
      wb.i_direc_reg     = dir;
      wb.i_reg_write     = rw;
      wb.i_mem_to_reg    = m2r;
      wb.i_j_return_dest = jal;
      wb.i_load_size     = size;
      wb.i_load_unsigned = uns;
      wb.i_byte_offset   = off;
      wb.i_valid         = v;
   endtask

   task automatic idle();
      set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wb.i_stall = 1'b0;
      wb.i_flush = 1'b0;
      idle();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic instr_a();
      set_in(32'h0, 32'hCAFE0001, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1);
   endtask

   task automatic instr_b();
      set_in(32'h0, 32'hDEAD0002, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1);
   endtask

   // Reference load result, from byte arithmetic on the memory word.
   function automatic logic [31:0] ref_load(input logic [31:0] mem, input int size,
                                            input bit uns, input int off);
      logic [31:0] v;
      if (size == 0) begin
         v = (mem >> (8 * off)) & 32'hFF;
         if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (size == 1) begin
         v = (mem >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
         if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = mem;
      end
      return v;
   endfunction

   typedef struct {
      logic [31:0] mem, alu, pc;
      logic [4:0]  dir;
      logic        rw, m2r, jal;
      logic [1:0]  size;
      logic        uns;
      logic [1:0]  off;
      logic        v;
      logic [31:0] e_dato;
      logic [4:0]  e_dir;
      logic        e_rw;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] mem, input logic [31:0] alu, input logic [31:0] pc,
                               input logic [4:0] dir, input logic rw, input logic m2r, input logic jal,
                               input logic [1:0] size, input logic uns, input logic [1:0] off,
                               input logic v, input logic [31:0] e_dato, input logic [4:0] e_dir,
                               input logic e_rw);
      vec_t r;
      r.mem = mem; r.alu = alu; r.pc = pc; r.dir = dir; r.rw = rw; r.m2r = m2r; r.jal = jal;
      r.size = size; r.uns = uns; r.off = off; r.v = v;
      r.e_dato = e_dato; r.e_dir = e_dir; r.e_rw = e_rw;
      return r;
   endfunction

   vec_t vecs[13];

   // Model state: what the register file should see after the next edge.
   bit          m_valid, m_rw, m_known;
   logic [31:0] m_dato;
   logic [4:0]  m_dir;
   int unsigned m_cnt;

   initial begin
      logic [31:0] X = 32'h80FF7F01;
      logic [31:0] A = 32'h0BAD0BAD;
      logic [31:0] P = 32'h00400008;
      vecs[0]  = mk(X, A, P, 5'd8, 1, 1, 0, 2'b00, 0, 2'd2, 1, 32'hFFFFFFFF, 5'd8, 1);
      vecs[1]  = mk(X, A, P, 5'd8, 1, 1, 0, 2'b00, 1, 2'd3, 1, 32'h00000080, 5'd8, 1);
      vecs[2]  = mk(X, A, P, 5'd8, 1, 1, 0, 2'b01, 0, 2'd0, 1, 32'h00007F01, 5'd8, 1);
      vecs[3]  = mk(X, A, P, 5'd8, 1, 1, 0, 2'b01, 0, 2'd3, 1, 32'hFFFF80FF, 5'd8, 1);
      vecs[4]  = mk(X, A, P, 5'd8, 1, 1, 0, 2'b10, 0, 2'd1, 1, 32'h80FF7F01, 5'd8, 1);
      vecs[5]  = mk(X, A, P, 5'd8, 1, 1, 0, 2'b11, 0, 2'd1, 1, 32'h80FF7F01, 5'd8, 1);
      vecs[6]  = mk(X, A, P, 5'd8, 1, 1, 0, 2'b00, 0, 2'd1, 1, 32'h0000007F, 5'd8, 1);
      vecs[7]  = mk(X, A, P, 5'd8, 1, 1, 0, 2'b01, 1, 2'd2, 1, 32'h000080FF, 5'd8, 1);
      vecs[8]  = mk(X, A, 32'h00400010, 5'd7, 1, 1, 1, 2'b10, 0, 2'd0, 1, 32'h00400010, 5'd31, 1);
      vecs[9]  = mk(X, A, P, 5'd0, 1, 0, 0, 2'b10, 0, 2'd0, 1, A, 5'd0, 0);
      vecs[10] = mk(X, A, P, 5'd3, 1, 0, 0, 2'b10, 0, 2'd0, 0, A, 5'd3, 0);
      vecs[11] = mk(X, A, P, 5'd4, 0, 0, 0, 2'b10, 0, 2'd0, 1, A, 5'd4, 0);
      vecs[12] = mk(X, 32'hFEEDF00D, P, 5'd12, 1, 0, 0, 2'b00, 0, 2'd3, 1, 32'hFEEDF00D, 5'd12, 1);

      // Reset then idle
      rst = 1'b1;
      wb.i_stall = 1'b0;
      wb.i_flush = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      chk("reset_dato", wb.o_dato, 32'h0);
      chk("reset_dir", 32'(wb.o_direccion), 32'h0);
      chk("reset_rw", 32'(wb.o_reg_write), 32'h0);
      chk("reset_valid", 32'(wb.o_valid), 32'h0);
      chk("reset_count", wb.o_retired_count, 32'h0);
      chk("reset_count4", 32'(wb4.o_retired_count), 32'h0);

      // First ALU write and its retirement
      rst = 1'b0;
      set_in(32'h0, 32'h12345678, 32'h0, 5'd5, 1, 0, 0, 2'b10, 0, 2'd0, 1);
      @(negedge clk);
      chk("alu_dato", wb.o_dato, 32'h12345678);
      chk("alu_dir", 32'(wb.o_direccion), 32'd5);
      chk("alu_rw", 32'(wb.o_reg_write), 32'd1);
      chk("alu_count0", wb.o_retired_count, 32'd0);
      idle();
      @(negedge clk);
      chk("alu_count1", wb.o_retired_count, 32'd1);

      // Directed vector table
      for (int i = 0; i < 13; i++) begin
         set_in(vecs[i].mem, vecs[i].alu, vecs[i].pc, vecs[i].dir, vecs[i].rw, vecs[i].m2r,
                vecs[i].jal, vecs[i].size, vecs[i].uns, vecs[i].off, vecs[i].v);
         @(negedge clk);
         chk($sformatf("vec%0d_dato", i), wb.o_dato, vecs[i].e_dato);
         chk($sformatf("vec%0d_dir", i), 32'(wb.o_direccion), 32'(vecs[i].e_dir));
         chk($sformatf("vec%0d_rw", i), 32'(wb.o_reg_write), 32'(vecs[i].e_rw));
      end

      // Stall held three cycles: outputs and counter frozen
      do_reset();
      instr_a();
      @(negedge clk);
      chk("stall_pre_dato", wb.o_dato, 32'hCAFE0001);
      chk("stall_pre_count", wb.o_retired_count, 32'd0);
      wb.i_stall = 1'b1;
      instr_b();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_dato", k), wb.o_dato, 32'hCAFE0001);
         chk($sformatf("stall%0d_dir", k), 32'(wb.o_direccion), 32'd9);
         chk($sformatf("stall%0d_rw", k), 32'(wb.o_reg_write), 32'd1);
         chk($sformatf("stall%0d_count", k), wb.o_retired_count, 32'd0);
      end
      wb.i_stall = 1'b0;
      idle();
      @(negedge clk);
      chk("unstall_count", wb.o_retired_count, 32'd1);
      chk("unstall_valid", 32'(wb.o_valid), 32'd0);

      // Flush together with stall: squash wins, nothing counted
      instr_a();
      @(negedge clk);
      wb.i_flush = 1'b1;
      wb.i_stall = 1'b1;
      instr_b();
      @(negedge clk);
      chk("flush_stall_valid", 32'(wb.o_valid), 32'd0);
      chk("flush_stall_rw", 32'(wb.o_reg_write), 32'd0);
      chk("flush_stall_count", wb.o_retired_count, 32'd1);

      // Flush alone still counts the outgoing instruction
      wb.i_flush = 1'b0;
      wb.i_stall = 1'b0;
      instr_a();
      @(negedge clk);
      wb.i_flush = 1'b1;
      instr_b();
      @(negedge clk);
      chk("flush_count", wb.o_retired_count, 32'd2);
      chk("flush_valid", 32'(wb.o_valid), 32'd0);
      chk("flush_rw", 32'(wb.o_reg_write), 32'd0);
      wb.i_flush = 1'b0;

      // Reset mid-stall with count=5
      do_reset();
      instr_a();
      repeat (6) @(negedge clk);
      chk("pre_rst_count", wb.o_retired_count, 32'd5);
      chk("pre_rst_valid", 32'(wb.o_valid), 32'd1);
      wb.i_stall = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_dato", wb.o_dato, 32'h0);
      chk("midrst_dir", 32'(wb.o_direccion), 32'h0);
      chk("midrst_rw", 32'(wb.o_reg_write), 32'h0);
      chk("midrst_valid", 32'(wb.o_valid), 32'h0);
      chk("midrst_count", wb.o_retired_count, 32'h0);
      rst = 1'b0;
      wb.i_stall = 1'b0;
      instr_b();
      @(negedge clk);
      chk("postrst_dato", wb.o_dato, 32'hDEAD0002);
      chk("postrst_dir", 32'(wb.o_direccion), 32'd10);
      chk("postrst_count", wb.o_retired_count, 32'd0);

      // Counter wrap on the 4-bit instance
      do_reset();
      instr_a();
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         chk($sformatf("wrap%0d_count4", k), 32'(wb4.o_retired_count), 32'((k - 1) % 16));
         chk($sformatf("wrap%0d_count", k), wb.o_retired_count, 32'(k - 1));
      end

      // Randomized traffic against the model
      do_reset();
      m_valid = 0; m_rw = 0; m_known = 1; m_dato = '0; m_dir = '0; m_cnt = 0;
      for (int n = 0; n < 400; n++) begin
         logic [31:0] mem, alu, pc;
         logic [4:0]  dir, e_dir;
         logic        rw, m2r, jal, uns, v, st, fl, rs;
         logic [1:0]  size, off;
         mem = $urandom; alu = $urandom; pc = $urandom;
         dir = 5'($urandom_range(0, 31));
         rw = 1'($urandom_range(0, 1)); m2r = 1'($urandom_range(0, 1));
         jal = ($urandom_range(0, 5) == 0);
         size = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
         off = 2'($urandom_range(0, 3));
         v = ($urandom_range(0, 4) != 0);
         st = ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 9) == 0);
         rs = ($urandom_range(0, 31) == 0);
         set_in(mem, alu, pc, dir, rw, m2r, jal, size, uns, off, v);
         wb.i_stall = st;
         wb.i_flush = fl;
         rst = rs;

         if (rs) begin
            m_valid = 0; m_rw = 0; m_known = 1; m_dato = '0; m_dir = '0; m_cnt = 0;
         end else begin
            if (m_valid && !st) m_cnt++;
            if (fl) begin
               m_valid = 0; m_rw = 0; m_known = 0;
            end else if (!st) begin
               e_dir   = jal ? 5'd31 : dir;
               m_valid = v;
               m_rw    = v && rw && (e_dir != 0);
               m_dir   = e_dir;
               m_dato  = jal ? pc : (m2r ? ref_load(mem, int'(size), uns, int'(off)) : alu);
               m_known = 1;
            end
         end

         @(negedge clk);
         chk($sformatf("rnd%0d_valid", n), 32'(wb.o_valid), 32'(m_valid));
         chk($sformatf("rnd%0d_rw", n), 32'(wb.o_reg_write), 32'(m_rw));
         chk($sformatf("rnd%0d_count", n), wb.o_retired_count, m_cnt);
         chk($sformatf("rnd%0d_count4", n), 32'(wb4.o_retired_count), m_cnt % 16);
         chk($sformatf("rnd%0d_rw4", n), 32'(wb4.o_reg_write), 32'(m_rw));
         if (m_known) begin
            chk($sformatf("rnd%0d_dato", n), wb.o_dato, m_dato);
            chk($sformatf("rnd%0d_dir", n), 32'(wb.o_direccion), 32'(m_dir));
            chk($sformatf("rnd%0d_dato4", n), wb4.o_dato, m_dato);
            chk($sformatf("rnd%0d_dir4", n), 32'(wb4.o_direccion), 32'(m_dir));
         end
      end
      rst = 1'b0;
      chk("final_valid4", 32'(wb4.o_valid), 32'(m_valid));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
